// File: rtl/pc_update_unit.sv
// Next-PC engine: owns the architectural PC, hands it to the IFU, applies the
// resolved branch decision from the EXU, halts on misaligned targets.
module pc_update_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned     CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_a_src,
    input  logic [1:0]       pc_b_src,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  csr_pc,
    input  logic             exu_valid,
    output logic             exu_ready,
    output logic             ifu_valid,
    input  logic             ifu_ready,
    output logic [XLEN-1:0]  pc,
    output logic             misalign,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ifu_valid_d;
    logic             exu_ready_d;
    logic             misalign_d;
    logic             halted_d;

    logic [XLEN-1:0]  off;
    logic [XLEN-1:0]  target;
    logic             target_mis;

    // Branch target; the jalr bit-0 clear happens before the alignment check.
    always_comb begin
        off = pc_a_src ? imm : XLEN'(4);
        case (pc_b_src)
            2'd0:    target = pc + off;
            2'd1:    target = (rs1 + off) & ~XLEN'(1);
            2'd2:    target = csr_pc;
            default: target = pc + XLEN'(4);
        endcase
        target_mis = |target[1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc;
        cnt_d       = retire_cnt;
        ifu_valid_d = ifu_valid;
        exu_ready_d = exu_ready;
        misalign_d  = 1'b0;
        halted_d    = halted;

        case (state_q)
            IDLE: begin
                state_d     = ISSUE;
                ifu_valid_d = 1'b1;
            end
            ISSUE: begin
                if (ifu_valid && ifu_ready) begin
                    state_d     = WAIT;
                    ifu_valid_d = 1'b0;
                    exu_ready_d = 1'b1;
                end
            end
            WAIT: begin
                if (exu_valid && exu_ready) begin
                    exu_ready_d = 1'b0;
                    if (target_mis) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                        halted_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        pc_d        = target;
                        cnt_d       = retire_cnt + CNT_W'(1);
                        ifu_valid_d = 1'b1;
                    end
                end
            end
            HALT: begin
                ifu_valid_d = 1'b0;
                exu_ready_d = 1'b0;
                halted_d    = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                ifu_valid_d = 1'b0;
                exu_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc         <= RESET_PC;
            retire_cnt <= '0;
            ifu_valid  <= 1'b0;
            exu_ready  <= 1'b0;
            misalign   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            retire_cnt <= cnt_d;
            ifu_valid  <= ifu_valid_d;
            exu_ready  <= exu_ready_d;
            misalign   <= misalign_d;
            halted     <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: driver queues expected issued PCs and
// misalign events, a negedge monitor pops and compares them.
module tb_pc_update_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_a_src;
    logic [1:0]  pc_b_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] csr_pc;
    logic        exu_valid;
    logic        exu_ready;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [31:0] pc;
    logic        misalign;
    logic        halted;
    logic [63:0] retire_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] cnt;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] misq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] mcnt     = 0;

    pc_update_unit dut (
        .clk(clk), .rst(rst),
        .pc_a_src(pc_a_src), .pc_b_src(pc_b_src),
        .imm(imm), .rs1(rs1), .csr_pc(csr_pc),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
        .pc(pc), .misalign(misalign), .halted(halted),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every IFU handshake and every misalign pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst && ifu_valid && ifu_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_issue", 64'(pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("issue_pc", 64'(pc), 64'(e.pc));
                chk("issue_retire_cnt", retire_cnt, e.cnt);
            end
        end
        if (!rst && misalign) begin
            if (misq.size() == 0) begin
                chk("unexpected_misalign", 64'(misalign), 64'd0);
            end else begin
                logic [31:0] mp;
                mp = misq.pop_front();
                chk("misalign_pc_held", 64'(pc), 64'(mp));
                chk("misalign_halted", 64'(halted), 64'd1);
                chk("misalign_ifu_valid", 64'(ifu_valid), 64'd0);
            end
        end
    end

    task automatic wait_exu_ready();
        int n;
        n = 0;
        while (!exu_ready && n < 40) begin
            tick();
            n++;
        end
        if (!exu_ready) chk("exu_ready_timeout", 64'(exu_ready), 64'd1);
    endtask

    // Present one branch decision; expected target or misalign event goes to the scoreboard.
    task automatic exu_op(input logic a, input logic [1:0] b, input logic [31:0] im,
                          input logic [31:0] r1, input logic [31:0] cp,
                          input logic [31:0] exp_pc, input logic mis);
        exp_t e;
        logic [31:0] cur;
        wait_exu_ready();
        cur       = pc;
        pc_a_src  = a;
        pc_b_src  = b;
        imm       = im;
        rs1       = r1;
        csr_pc    = cp;
        exu_valid = 1'b1;
        if (mis) begin
            misq.push_back(cur);
        end else begin
            mcnt  = mcnt + 64'd1;
            e.pc  = exp_pc;
            e.cnt = mcnt;
            expq.push_back(e);
        end
        tick();
        exu_valid = 1'b0;
        pc_a_src  = 1'b0;
        pc_b_src  = 2'd0;
        imm       = 32'hDEAD_BEEF;
        rs1       = 32'hDEAD_BEEF;
        csr_pc    = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        exp_t e;
        rst       = 1'b1;
        exu_valid = 1'b0;
        tick();
        tick();
        expq.delete();
        misq.delete();
        mcnt  = 0;
        e.pc  = RST_PC;
        e.cnt = 0;
        expq.push_back(e);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        pc_a_src  = 1'b0;
        pc_b_src  = 2'd0;
        imm       = '0;
        rs1       = '0;
        csr_pc    = '0;
        exu_valid = 1'b0;
        ifu_ready = 1'b1;
        tick();
        tick();
        chk("rst_pc", 64'(pc), 64'(RST_PC));
        chk("rst_ifu_valid", 64'(ifu_valid), 64'd0);
        chk("rst_exu_ready", 64'(exu_ready), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        chk("rst_retire_cnt", retire_cnt, 64'd0);

        do_reset();
        tick();
        chk("first_ifu_valid", 64'(ifu_valid), 64'd1);

        // Sequential fall-through
        exu_op(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h8000_0004, 1'b0);
        exu_op(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h8000_0008, 1'b0);
        exu_op(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h8000_000C, 1'b0);
        // Back to 0x8000_0000 via csr, then taken branches both directions
        exu_op(1'b0, 2'd2, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        exu_op(1'b1, 2'd0, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h7FFF_FFF0, 1'b0);
        exu_op(1'b0, 2'd2, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        exu_op(1'b1, 2'd0, 32'h0000_0010, 32'h0, 32'h0, 32'h8000_0010, 1'b0);
        // jalr with bit-0 masked, ecall ignoring imm, reserved fall-through
        exu_op(1'b1, 2'd1, 32'h0, 32'h8000_1001, 32'h0, 32'h8000_1000, 1'b0);
        exu_op(1'b1, 2'd2, 32'h0000_0044, 32'h0, 32'h8000_0100, 32'h8000_0100, 1'b0);
        exu_op(1'b1, 2'd3, 32'h0000_0040, 32'h0, 32'h0, 32'h8000_0104, 1'b0);

        // Backpressure in ISSUE with a stray exu_valid pulse
        exu_op(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h8000_0108, 1'b0);
        ifu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exu_valid = (i == 2);
            pc_a_src  = 1'b1;
            imm       = 32'h0000_1000;
            tick();
            chk("bp_ifu_valid", 64'(ifu_valid), 64'd1);
            chk("bp_pc", 64'(pc), 64'h8000_0108);
            chk("bp_exu_ready", 64'(exu_ready), 64'd0);
        end
        exu_valid = 1'b0;
        pc_a_src  = 1'b0;
        ifu_ready = 1'b1;

        // Async reset mid-WAIT with exu_valid high
        wait_exu_ready();
        chk("pre_rst_cnt", retire_cnt, 64'd11);
        pc_a_src  = 1'b1;
        imm       = 32'h0000_0100;
        exu_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", 64'(pc), 64'(RST_PC));
        chk("async_rst_cnt", retire_cnt, 64'd0);
        chk("async_rst_exu_ready", 64'(exu_ready), 64'd0);
        do_reset();

        // Wrap-around and misaligned jalr
        exu_op(1'b0, 2'd2, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        exu_op(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
        exu_op(1'b1, 2'd1, 32'h0, 32'h8000_1003, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exu_valid = 1'b1;
            tick();
        end
        exu_valid = 1'b0;
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_misalign_pulse_done", 64'(misalign), 64'd0);
        chk("halt_ifu_valid", 64'(ifu_valid), 64'd0);
        chk("halt_exu_ready", 64'(exu_ready), 64'd0);
        chk("halt_pc", 64'(pc), 64'd0);
        chk("halt_cnt", retire_cnt, 64'd2);

        // Misaligned pc+imm target (bit 1 set)
        do_reset();
        exu_op(1'b1, 2'd0, 32'h0000_0006, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        chk("halt2_halted", 64'(halted), 64'd1);
        chk("halt2_pc", 64'(pc), 64'(RST_PC));
        chk("halt2_cnt", retire_cnt, 64'd0);

        chk("exp_queue_drained", 64'(expq.size()), 64'd0);
        chk("mis_queue_drained", 64'(misq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
